serial_frame_controller: RTL and testbench

//  Sequences the byte stream of the UART serial receiver into checked frames.

---
 rtl/serial_frame_controller_if.sv | 38 +++
 rtl/serial_frame_controller.sv | 196 +++++++++++++++++++
 tb/tb_serial_frame_controller.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_controller_if.sv
// Bus bundle between the UART receiver / command decoder and serial_frame_controller.
//   IN_RX_DATA      [7:0] receiver data output
//   IN_RX_READY           receiver ready/idle status (rising edge = one byte)
//   IN_FRAME_ACK          consumer has taken the held frame
//   IN_RD_ADDR      [7:0] payload read index
//   OUT_RD_DATA     [7:0] payload[IN_RD_ADDR], combinational
//   OUT_FRAME_LEN   [7:0] payload length of the held frame
//   OUT_FRAME_VALID       checked frame is held
//   OUT_ERR_LEN           1-cycle pulse, bad LEN byte
//   OUT_ERR_CHK           1-cycle pulse, checksum mismatch
//   OUT_ERR_TIMEOUT       1-cycle pulse, inter-byte timeout
//   OUT_OVERRUN           1-cycle pulse, byte dropped while holding a frame
// slave modport is the controller's view; master is the environment's view.
interface serial_frame_controller_if;
  logic [7:0] IN_RX_DATA;
  logic       IN_RX_READY;
  logic       IN_FRAME_ACK;
  logic [7:0] IN_RD_ADDR;
  logic [7:0] OUT_RD_DATA;
  logic [7:0] OUT_FRAME_LEN;
  logic       OUT_FRAME_VALID;
  logic       OUT_ERR_LEN;
  logic       OUT_ERR_CHK;
  logic       OUT_ERR_TIMEOUT;
  logic       OUT_OVERRUN;

  modport slave (
    input  IN_RX_DATA, IN_RX_READY, IN_FRAME_ACK, IN_RD_ADDR,
    output OUT_RD_DATA, OUT_FRAME_LEN, OUT_FRAME_VALID,
           OUT_ERR_LEN, OUT_ERR_CHK, OUT_ERR_TIMEOUT, OUT_OVERRUN
  );

  modport master (
    output IN_RX_DATA, IN_RX_READY, IN_FRAME_ACK, IN_RD_ADDR,
    input  OUT_RD_DATA, OUT_FRAME_LEN, OUT_FRAME_VALID,
           OUT_ERR_LEN, OUT_ERR_CHK, OUT_ERR_TIMEOUT, OUT_OVERRUN
  );
endinterface

// File: rtl/serial_frame_controller.sv
// serial_frame_controller: turns the UART receiver byte stream into checked
// frames SYNC | LEN | PAYLOAD[LEN] | CHK and holds one frame under valid/ack.
// Ports:
//   BCLK   baud-rate clock shared with the receiver
//   RESET  synchronous, active-high
//   bus    serial_frame_controller_if.slave (receiver inputs, ack, payload
//          read port, frame status and error pulses)
// Optional feature: define FRAME_TIMEOUT_EN to abort partial frames after
// TIMEOUT_CYCLES BCLK cycles without a byte; otherwise OUT_ERR_TIMEOUT is 0.
module serial_frame_controller #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input logic                        BCLK,
  input logic                        RESET,
  serial_frame_controller_if.slave   bus
);

  localparam int unsigned DW    = 8;
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_HUNT, S_LEN, S_PAYLOAD, S_CHECK, S_HOLD
  } state_t;

  state_t          r_state,       w_state_nxt;
  logic            r_ready_prev;
  logic [DW-1:0]   r_idx,         w_idx_nxt;
  logic [DW-1:0]   r_sum,         w_sum_nxt;
  logic [DW-1:0]   r_len,         w_len_nxt;
  logic [DW-1:0]   r_frame_len,   w_frame_len_nxt;
  logic            r_frame_valid, w_frame_valid_nxt;
  logic            r_err_len,     w_err_len_nxt;
  logic            r_err_chk,     w_err_chk_nxt;
  logic            r_overrun,     w_overrun_nxt;
  logic            w_buf_we;
  logic [DW-1:0]   r_buf [MAX_LEN];

  logic            w_stb;
  logic [DW-1:0]   w_sum_chk;

  // A byte arrives on each rising edge of the receiver's ready line.
  assign w_stb     = bus.IN_RX_READY & ~r_ready_prev;
  assign w_sum_chk = r_sum + bus.IN_RX_DATA;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic            r_err_timeout, w_err_timeout_nxt;
`else
  logic            w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_sum_nxt         = r_sum;
    w_len_nxt         = r_len;
    w_frame_len_nxt   = r_frame_len;
    w_frame_valid_nxt = r_frame_valid;
    w_err_len_nxt     = 1'b0;
    w_err_chk_nxt     = 1'b0;
    w_overrun_nxt     = 1'b0;
    w_buf_we          = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    w_to_cnt_nxt      = '0;
    w_err_timeout_nxt = 1'b0;
`endif

    case (r_state)
      S_HUNT: begin
        if (w_stb && (bus.IN_RX_DATA == SYNC_BYTE)) begin
          w_state_nxt = S_LEN;
          w_sum_nxt   = '0;
        end
      end
      S_LEN: begin
        if (w_stb) begin
          if ((bus.IN_RX_DATA == 8'h00) || (bus.IN_RX_DATA > DW'(MAX_LEN))) begin
            w_state_nxt   = S_HUNT;
            w_err_len_nxt = 1'b1;
          end else begin
            w_len_nxt   = bus.IN_RX_DATA;
            w_sum_nxt   = bus.IN_RX_DATA;
            w_idx_nxt   = '0;
            w_state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_stb) begin
          w_buf_we  = 1'b1;
          w_sum_nxt = w_sum_chk;
          w_idx_nxt = r_idx + 8'd1;
          if (r_idx == (r_len - 8'd1)) begin
            w_state_nxt = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (w_stb) begin
          if (w_sum_chk == 8'h00) begin
            w_state_nxt       = S_HOLD;
            w_frame_valid_nxt = 1'b1;
            w_frame_len_nxt   = r_len;
          end else begin
            w_state_nxt   = S_HUNT;
            w_err_chk_nxt = 1'b1;
          end
        end
      end
      S_HOLD: begin
        // Held frame is frozen; incoming bytes are dropped and flagged.
        w_overrun_nxt = w_stb;
        if (bus.IN_FRAME_ACK) begin
          w_state_nxt       = S_HUNT;
          w_frame_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_HUNT;
    endcase

`ifdef FRAME_TIMEOUT_EN
    // Inter-byte timer runs only while a frame is partially received.
    if ((r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK)) begin
      if (!w_stb) begin
        if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt       = S_HUNT;
          w_err_timeout_nxt = 1'b1;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge BCLK) begin
    if (RESET) begin
      r_state       <= S_HUNT;
      r_ready_prev  <= 1'b1;
      r_idx         <= '0;
      r_sum         <= '0;
      r_len         <= '0;
      r_frame_len   <= '0;
      r_frame_valid <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_chk     <= 1'b0;
      r_overrun     <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_ready_prev  <= bus.IN_RX_READY;
      r_idx         <= w_idx_nxt;
      r_sum         <= w_sum_nxt;
      r_len         <= w_len_nxt;
      r_frame_len   <= w_frame_len_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_err_len     <= w_err_len_nxt;
      r_err_chk     <= w_err_chk_nxt;
      r_overrun     <= w_overrun_nxt;
`ifdef FRAME_TIMEOUT_EN
      r_to_cnt      <= w_to_cnt_nxt;
      r_err_timeout <= w_err_timeout_nxt;
`endif
    end
  end

  // Payload buffer; contents are not reset, reads are gated by frame length.
  always_ff @(posedge BCLK) begin
    if (w_buf_we) begin
      r_buf[IDX_W'(r_idx)] <= bus.IN_RX_DATA;
    end
  end

  assign bus.OUT_RD_DATA     = (bus.IN_RD_ADDR < r_frame_len) ?
                               r_buf[IDX_W'(bus.IN_RD_ADDR)] : 8'h00;
  assign bus.OUT_FRAME_LEN   = r_frame_len;
  assign bus.OUT_FRAME_VALID = r_frame_valid;
  assign bus.OUT_ERR_LEN     = r_err_len;
  assign bus.OUT_ERR_CHK     = r_err_chk;
  assign bus.OUT_OVERRUN     = r_overrun;
`ifdef FRAME_TIMEOUT_EN
  assign bus.OUT_ERR_TIMEOUT = r_err_timeout;
`else
  assign bus.OUT_ERR_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_controller.sv
// Directed bench for serial_frame_controller (SYNC=AA, MAX_LEN=16, TIMEOUT=40).
module tb_serial_frame_controller;

  logic BCLK = 1'b0;
  logic RESET;
  always #5 BCLK = ~BCLK;

  serial_frame_controller_if bus();

  serial_frame_controller dut (
    .BCLK  (BCLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // kind 0: one received byte (ack applied in its stb cycle); kind 1: ack-only cycle
  typedef struct {
    logic        kind;
    logic [7:0]  data;
    logic        ack;
    logic        exp_valid;
    logic [7:0]  exp_len;
    logic        exp_elen;
    logic        exp_echk;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic kind, input logic [7:0] data, input logic ack,
                              input logic v, input logic [7:0] len,
                              input logic el, input logic ec, input logic o);
    vec_t r;
    r.kind = kind; r.data = data; r.ack = ack;
    r.exp_valid = v; r.exp_len = len; r.exp_elen = el; r.exp_echk = ec; r.exp_ovr = o;
    return r;
  endfunction

  function automatic logic [12:0] status();
    return {bus.OUT_FRAME_VALID, bus.OUT_FRAME_LEN, bus.OUT_ERR_LEN,
            bus.OUT_ERR_CHK, bus.OUT_ERR_TIMEOUT, bus.OUT_OVERRUN};
  endfunction

  task automatic tick();
    @(posedge BCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    bus.IN_RX_DATA  = b;
    bus.IN_RX_READY = 1'b0;
    tick();
    bus.IN_RX_READY  = 1'b1;
    bus.IN_FRAME_ACK = ack;
    tick();
    bus.IN_FRAME_ACK = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.IN_FRAME_ACK = 1'b1;
    tick();
    bus.IN_FRAME_ACK = 1'b0;
  endtask

  task automatic check_rd(input logic [7:0] addr, input logic [7:0] exp);
    bus.IN_RD_ADDR = addr;
    #1;
    check($sformatf("rd[%0d]", addr), 32'(bus.OUT_RD_DATA), 32'(exp));
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (vecs[i].kind) pulse_ack();
      else send_byte(vecs[i].data, vecs[i].ack);
      check($sformatf("vec%0d", i), 32'(status()),
            32'({vecs[i].exp_valid, vecs[i].exp_len, vecs[i].exp_elen,
                 vecs[i].exp_echk, 1'b0, vecs[i].exp_ovr}));
    end
  endtask

  initial begin
    int n_to;

    // 0..5: AA,03,11,22,33,97 -> frame len 3
    vecs.push_back(mk(0, 8'hAA, 0, 0, 8'd0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h03, 0, 0, 8'd0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h11, 0, 0, 8'd0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h22, 0, 0, 8'd0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h33, 0, 0, 8'd0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h97, 0, 1, 8'd3, 0, 0, 0));
    // 6..7: overrun while held, then ack
    vecs.push_back(mk(0, 8'h55, 0, 1, 8'd3, 0, 0, 1));
    vecs.push_back(mk(1, 8'h00, 1, 0, 8'd3, 0, 0, 0));
    // 8..17: bad checksum then good frame AA,02,10,20,CE
    vecs.push_back(mk(0, 8'hAA, 0, 0, 8'd3, 0, 0, 0));
    vecs.push_back(mk(0, 8'h02, 0, 0, 8'd3, 0, 0, 0));
    vecs.push_back(mk(0, 8'h10, 0, 0, 8'd3, 0, 0, 0));
    vecs.push_back(mk(0, 8'h20, 0, 0, 8'd3, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'd3, 0, 1, 0));
    vecs.push_back(mk(0, 8'hAA, 0, 0, 8'd3, 0, 0, 0));
    vecs.push_back(mk(0, 8'h02, 0, 0, 8'd3, 0, 0, 0));
    vecs.push_back(mk(0, 8'h10, 0, 0, 8'd3, 0, 0, 0));
    vecs.push_back(mk(0, 8'h20, 0, 0, 8'd3, 0, 0, 0));
    vecs.push_back(mk(0, 8'hCE, 0, 1, 8'd2, 0, 0, 0));
    // 18: byte arriving in the ack cycle -> overrun and release
    vecs.push_back(mk(0, 8'h55, 1, 0, 8'd2, 0, 0, 1));
    // 19..27: LEN 0 and LEN 17 rejected, then AA,01,07,F8 accepted
    vecs.push_back(mk(0, 8'hAA, 0, 0, 8'd2, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'd2, 1, 0, 0));
    vecs.push_back(mk(0, 8'hAA, 0, 0, 8'd2, 0, 0, 0));
    vecs.push_back(mk(0, 8'h11, 0, 0, 8'd2, 1, 0, 0));
    vecs.push_back(mk(0, 8'hAA, 0, 0, 8'd2, 0, 0, 0));
    vecs.push_back(mk(0, 8'h01, 0, 0, 8'd2, 0, 0, 0));
    vecs.push_back(mk(0, 8'h07, 0, 0, 8'd2, 0, 0, 0));
    vecs.push_back(mk(0, 8'hF8, 0, 1, 8'd1, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 1, 0, 8'd1, 0, 0, 0));
    // 28..35: ack outside HOLD is ignored
    vecs.push_back(mk(1, 8'h00, 1, 0, 8'd1, 0, 0, 0));
    vecs.push_back(mk(0, 8'hAA, 0, 0, 8'd1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h02, 0, 0, 8'd1, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 1, 0, 8'd1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h10, 0, 0, 8'd1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h20, 0, 0, 8'd1, 0, 0, 0));
    vecs.push_back(mk(0, 8'hCE, 0, 1, 8'd2, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 1, 0, 8'd2, 0, 0, 0));
    // 36..41: receiver-reset strobe (00), stray 12, then AA,01,AA,55
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'd2, 0, 0, 0));
    vecs.push_back(mk(0, 8'h12, 0, 0, 8'd2, 0, 0, 0));
    vecs.push_back(mk(0, 8'hAA, 0, 0, 8'd2, 0, 0, 0));
    vecs.push_back(mk(0, 8'h01, 0, 0, 8'd2, 0, 0, 0));
    vecs.push_back(mk(0, 8'hAA, 0, 0, 8'd2, 0, 0, 0));
    vecs.push_back(mk(0, 8'h55, 0, 1, 8'd1, 0, 0, 0));
    // 42: release
    vecs.push_back(mk(1, 8'h00, 1, 0, 8'd1, 0, 0, 0));

    RESET            = 1'b1;
    bus.IN_RX_DATA   = 8'h00;
    bus.IN_RX_READY  = 1'b1;
    bus.IN_FRAME_ACK = 1'b0;
    bus.IN_RD_ADDR   = 8'h00;
    repeat (3) tick();
    RESET = 1'b0;
    tick();

    check("reset_status", 32'(status()), 32'h0);
    check_rd(8'd0, 8'h00);

    run_vecs(0, 5);
    check_rd(8'd0, 8'h11);
    check_rd(8'd1, 8'h22);
    check_rd(8'd2, 8'h33);
    check_rd(8'd3, 8'h00);
    run_vecs(6, 6);
    check_rd(8'd0, 8'h11);
    check_rd(8'd2, 8'h33);
    run_vecs(7, 17);
    check_rd(8'd0, 8'h10);
    check_rd(8'd1, 8'h20);
    check_rd(8'd2, 8'h00);
    check_rd(8'd255, 8'h00);
    run_vecs(18, 41);
    check_rd(8'd0, 8'hAA);
    check_rd(8'd1, 8'h00);
    run_vecs(42, 42);

    // RESET mid-frame: partial frame dropped silently, back to hunting
    send_byte(8'hAA, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("midreset_status", 32'(status()), 32'h0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h97, 1'b0);
    check("after_reset_tail", 32'(status()), 32'h0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h07, 1'b0);
    send_byte(8'hF8, 1'b0);
    check("after_reset_frame", 32'(status()), 32'({1'b1, 8'd1, 4'b0000}));
    pulse_ack();
    check("after_reset_ack", 32'(bus.OUT_FRAME_VALID), 32'h0);

    // Inter-byte idle: AA,02,10 then 45 quiet cycles
    send_byte(8'hAA, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h10, 1'b0);
    n_to = 0;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (bus.OUT_ERR_TIMEOUT === 1'b1) n_to++;
    end
`ifdef FRAME_TIMEOUT_EN
    check("timeout_pulses", 32'(n_to), 32'd1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'hCE, 1'b0);
`else
    check("timeout_pulses", 32'(n_to), 32'd0);
    send_byte(8'h20, 1'b0);
    send_byte(8'hCE, 1'b0);
`endif
    check("idle_frame", 32'(status()), 32'({1'b1, 8'd2, 4'b0000}));
    check_rd(8'd0, 8'h10);
    check_rd(8'd1, 8'h20);
    pulse_ack();
    check("final_release", 32'(bus.OUT_FRAME_VALID), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
